// File: rtl/mont_mul_arbiter_if.sv
// Requester + multiplier-core bus of mont_mul_arbiter.
// slave = arbiter side, master = requesters/core side.
interface mont_mul_arbiter_if #(
   parameter int N_REQ = 3,
   parameter int WIDTH = 255
);
   logic [N_REQ-1:0]       i_req;
   logic [N_REQ*WIDTH-1:0] i_a;
   logic [N_REQ*WIDTH-1:0] i_b;
   logic [N_REQ-1:0]       o_grant;
   logic [N_REQ-1:0]       o_done;
   logic [WIDTH-1:0]       o_result;
   logic                   o_busy;
   logic                   o_mm_start;
   logic [WIDTH-1:0]       o_mm_a;
   logic [WIDTH-1:0]       o_mm_b;
   logic [WIDTH-1:0]       i_mm_result;
   logic                   i_mm_finished;
   logic                   o_error;

   modport slave (
      input  i_req, i_a, i_b, i_mm_result, i_mm_finished,
      output o_grant, o_done, o_result, o_busy, o_mm_start, o_mm_a, o_mm_b, o_error
   );

   modport master (
      output i_req, i_a, i_b, i_mm_result, i_mm_finished,
      input  o_grant, o_done, o_result, o_busy, o_mm_start, o_mm_a, o_mm_b, o_error
   );
endinterface

// File: rtl/mont_mul_arbiter.sv
// Round-robin arbiter sharing one Montgomery multiplier among N_REQ requesters.
// Optional WAIT watchdog enabled by defining MM_ARB_TIMEOUT_EN.
module mont_mul_arbiter #(
   parameter int N_REQ          = 3,
   parameter int WIDTH          = 255,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic               i_clk,
   input logic               i_rst,
   mont_mul_arbiter_if.slave bus
);
   localparam int PW = $clog2(N_REQ);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("mont_mul_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   state_t           state_q, state_d;
   logic [PW-1:0]    owner_q, owner_d, ptr_q, ptr_d;
   logic [PW-1:0]    sel, owner_nxt;
   logic             any_req;
   logic [WIDTH-1:0] mm_a_q, mm_a_d, mm_b_q, mm_b_d, result_q, result_d;
   logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d;
   logic             start_q, start_d;

`ifdef MM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          error_q, error_d;
   logic          timeout;
   // A finish in the same cycle as the limit still wins.
   assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !bus.i_mm_finished;
`endif

   assign any_req   = |bus.i_req;
   assign owner_nxt = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

   // Scan downward in offset so the lowest offset from the pointer wins.
   always_comb begin
      logic [PW-1:0] idx;
      sel = ptr_q;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = PW'((32'(ptr_q) + 32'(k)) % 32'(N_REQ));
         if (bus.i_req[idx]) sel = idx;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         owner_q  <= '0;
         ptr_q    <= '0;
         mm_a_q   <= '0;
         mm_b_q   <= '0;
         result_q <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         start_q  <= 1'b0;
`ifdef MM_ARB_TIMEOUT_EN
         cnt_q    <= '0;
         error_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         mm_a_q   <= mm_a_d;
         mm_b_q   <= mm_b_d;
         result_q <= result_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         start_q  <= start_d;
`ifdef MM_ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
         error_q  <= error_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (any_req) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (bus.i_mm_finished) state_d = S_DONE;
`ifdef MM_ARB_TIMEOUT_EN
            else if (timeout)      state_d = S_IDLE;
`endif
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      mm_a_d   = mm_a_q;
      mm_b_d   = mm_b_q;
      result_d = result_q;
      grant_d  = '0;
      done_d   = '0;
      start_d  = 1'b0;
`ifdef MM_ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
      error_d  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               owner_d      = sel;
               grant_d[sel] = 1'b1;
               start_d      = 1'b1;
               for (int k = 0; k < N_REQ; k++) begin
                  if (sel == PW'(k)) begin
                     mm_a_d = bus.i_a[k*WIDTH +: WIDTH];
                     mm_b_d = bus.i_b[k*WIDTH +: WIDTH];
                  end
               end
            end
         end
         S_ISSUE: begin
`ifdef MM_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
         end
         S_WAIT: begin
            if (bus.i_mm_finished) result_d = bus.i_mm_result;
`ifdef MM_ARB_TIMEOUT_EN
            else if (timeout) begin
               result_d        = '0;
               done_d[owner_q] = 1'b1;
               error_d         = 1'b1;
               ptr_d           = owner_nxt;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         S_DONE: begin
            done_d[owner_q] = 1'b1;
            ptr_d           = owner_nxt;
         end
         default: ;
      endcase
   end

   assign bus.o_grant    = grant_q;
   assign bus.o_done     = done_q;
   assign bus.o_result   = result_q;
   assign bus.o_busy     = (state_q != S_IDLE);
   assign bus.o_mm_start = start_q;
   assign bus.o_mm_a     = mm_a_q;
   assign bus.o_mm_b     = mm_b_q;
`ifdef MM_ARB_TIMEOUT_EN
   assign bus.o_error    = error_q;
`else
   assign bus.o_error    = 1'b0;
`endif
endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Bench for mont_mul_arbiter: mock adder core (a+b), round-robin reference model,
// directed scenarios plus randomized request traffic.
module tb_mont_mul_arbiter;
   localparam int N  = 3;
   localparam int W  = 255;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mont_mul_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
   mont_mul_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Mock core: returns o_mm_a + o_mm_b core_lat cycles after start; shares reset.
   logic         core_en = 1'b1;
   int           core_lat = 5;
   logic         m_busy, m_fin;
   int           m_cnt;
   logic [W-1:0] m_res;
   logic         stray_fin = 1'b0;
   logic [W-1:0] stray_val = '0;

   assign bus.i_mm_finished = m_fin | stray_fin;
   assign bus.i_mm_result   = stray_fin ? stray_val : m_res;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_fin  <= 1'b0;
         m_cnt  <= 0;
         m_res  <= '0;
      end else begin
         m_fin <= 1'b0;
         if (m_busy) begin
            if (m_cnt <= 1) begin
               m_busy <= 1'b0;
               m_fin  <= 1'b1;
               m_res  <= bus.o_mm_a + bus.o_mm_b;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end else if (bus.o_mm_start && core_en) begin
            m_busy <= 1'b1;
            m_cnt  <= core_lat;
         end
      end
   end

   int done_cnt = 0;
   int start_cnt = 0;
   always @(negedge clk) begin
      if (bus.o_done !== '0) done_cnt <= done_cnt + 1;
      if (bus.o_mm_start === 1'b1) start_cnt <= start_cnt + 1;
   end

   int m_ptr = 0;

   function automatic logic [N-1:0] onehot(input int k);
      return N'(1) << k;
   endfunction

   // Round-robin rule: first requesting index at ptr, ptr+1, ... (mod N).
   function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
      logic [N-1:0] r;
      for (int j = 0; j < N; j++) begin
         r = req >> ((ptr + j) % N);
         if (r[0]) return (ptr + j) % N;
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] rnd_w();
      logic [8*32-1:0] t;
      for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
      return t[W-1:0];
   endfunction

   function automatic logic [W-1:0] get_a(input int k);
      return bus.i_a[k*W +: W];
   endfunction

   function automatic logic [W-1:0] get_b(input int k);
      return bus.i_b[k*W +: W];
   endfunction

   task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.i_a[k*W +: W] = a;
      bus.i_b[k*W +: W] = b;
   endtask

   task automatic do_reset(input logic [N-1:0] req_init);
      @(negedge clk);
      rst       = 1'b1;
      bus.i_req = req_init;
      stray_fin = 1'b0;
      core_en   = 1'b1;
      repeat (3) @(negedge clk);
      rst   = 1'b0;
      m_ptr = 0;
   endtask

   task automatic wait_grant(output logic [N-1:0] g, output bit ok);
      ok = 1'b0;
      g  = '0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus.o_grant !== '0) begin
            g  = bus.o_grant;
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(output logic [N-1:0] d, output logic [W-1:0] r, output bit ok);
      ok = 1'b0;
      d  = '0;
      r  = '0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (bus.o_done !== '0) begin
            d  = bus.o_done;
            r  = bus.o_result;
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_txn(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [N-1:0] d, output logic [W-1:0] r, output bit ok);
      logic [N-1:0] g;
      bit           okg;
      @(negedge clk);
      bus.i_req[k] = 1'b1;
      set_ops(k, a, b);
      wait_grant(g, okg);
      bus.i_req[k] = 1'b0;
      d  = '0;
      r  = '0;
      ok = 1'b0;
      if (okg) wait_done(d, r, ok);
   endtask

   task automatic test_reset();
      bus.i_a = '0;
      bus.i_b = '0;
      do_reset('0);
      checks++; if (bus.o_grant !== '0)    begin errors++; $display("FAIL rst_grant: got %b want 0", bus.o_grant); end
      checks++; if (bus.o_done !== '0)     begin errors++; $display("FAIL rst_done: got %b want 0", bus.o_done); end
      checks++; if (bus.o_mm_start !== 0)  begin errors++; $display("FAIL rst_start: got %b want 0", bus.o_mm_start); end
      checks++; if (bus.o_busy !== 0)      begin errors++; $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
      checks++; if (bus.o_error !== 0)     begin errors++; $display("FAIL rst_error: got %b want 0", bus.o_error); end
      checks++; if (bus.o_result !== '0)   begin errors++; $display("FAIL rst_result: got %h want 0", bus.o_result); end
      checks++; if (bus.o_mm_a !== '0 || bus.o_mm_b !== '0)
                  begin errors++; $display("FAIL rst_mm_ops: got a=%h b=%h want 0", bus.o_mm_a, bus.o_mm_b); end
      repeat (6) @(negedge clk);
      checks++; if (bus.o_busy !== 0 || bus.o_grant !== '0)
                  begin errors++; $display("FAIL idle_no_req: busy=%b grant=%b want 0/0", bus.o_busy, bus.o_grant); end
   endtask

   task automatic test_single();
      int f;
      int s0;
      s0 = start_cnt;
      core_lat = 5;
      @(negedge clk);
      bus.i_req[1] = 1'b1;
      set_ops(1, W'(7), W'(9));
      @(negedge clk);
      checks++; if (bus.o_grant !== 3'b010) begin errors++; $display("FAIL single_grant: got %b want 010", bus.o_grant); end
      checks++; if (bus.o_mm_start !== 1)   begin errors++; $display("FAIL single_start: got %b want 1", bus.o_mm_start); end
      bus.i_req[1] = 1'b0;
      set_ops(1, W'(100), W'(200));
      f = -1;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus.i_mm_finished === 1'b1) begin f = t; break; end
      end
      checks++; if (f < 0) begin errors++; $display("FAIL single_finish: core finish not seen, want within 50 cycles"); end
      @(negedge clk);
      checks++; if (bus.o_done !== '0) begin errors++; $display("FAIL single_done_early: got %b want 000 at finish+1", bus.o_done); end
      checks++; if (bus.o_mm_a !== W'(7) || bus.o_mm_b !== W'(9))
                  begin errors++; $display("FAIL single_ops_stable: got a=%0d b=%0d want 7/9", bus.o_mm_a, bus.o_mm_b); end
      @(negedge clk);
      checks++; if (bus.o_done !== 3'b010 || bus.o_result !== W'(16))
                  begin errors++; $display("FAIL single_done: got done=%b result=%0d want 010/16", bus.o_done, bus.o_result); end
      repeat (3) @(negedge clk);
      checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL single_start_count: got %0d want 1", start_cnt - s0); end
   endtask

   task automatic test_simultaneous();
      logic [W-1:0] a [N];
      logic [W-1:0] b [N];
      logic [W-1:0] e, r;
      logic [N-1:0] g, d;
      bit           ok;
      core_lat = 3;
      for (int k = 0; k < N; k++) begin
         a[k] = rnd_w();
         b[k] = rnd_w();
         set_ops(k, a[k], b[k]);
      end
      do_reset('1);
      for (int j = 0; j < 4; j++) begin
         wait_grant(g, ok);
         checks++; if (!ok || g !== onehot(j % N))
                     begin errors++; $display("FAIL sim_grant%0d: got %b want %b", j, g, onehot(j % N)); end
         wait_done(d, r, ok);
         e = a[j % N] + b[j % N];
         checks++; if (!ok || d !== onehot(j % N) || r !== e)
                     begin errors++; $display("FAIL sim_done%0d: got done=%b res=%h want %b/%h", j, d, r, onehot(j % N), e); end
      end
      bus.i_req = '0;
   endtask

   task automatic test_fairness();
      logic [W-1:0] a0, b0, a2, b2, e, r;
      logic [N-1:0] g, d;
      bit           ok;
      a0 = rnd_w(); b0 = rnd_w(); a2 = rnd_w(); b2 = rnd_w();
      set_ops(0, a0, b0);
      do_reset(3'b001);
      wait_grant(g, ok);
      checks++; if (!ok || g !== 3'b001) begin errors++; $display("FAIL fair_g0: got %b want 001", g); end
      bus.i_req[2] = 1'b1;
      set_ops(2, a2, b2);
      wait_done(d, r, ok);
      e = a0 + b0;
      checks++; if (!ok || d !== 3'b001 || r !== e) begin errors++; $display("FAIL fair_d0: got %b/%h want 001/%h", d, r, e); end
      wait_grant(g, ok);
      bus.i_req[2] = 1'b0;
      checks++; if (!ok || g !== 3'b100) begin errors++; $display("FAIL fair_g2: got %b want 100", g); end
      wait_done(d, r, ok);
      e = a2 + b2;
      checks++; if (!ok || d !== 3'b100 || r !== e) begin errors++; $display("FAIL fair_d2: got %b/%h want 100/%h", d, r, e); end
      wait_grant(g, ok);
      bus.i_req = '0;
      checks++; if (!ok || g !== 3'b001) begin errors++; $display("FAIL fair_g0b: got %b want 001", g); end
      wait_done(d, r, ok);
   endtask

   task automatic test_stray_finish();
      logic [N-1:0] d;
      logic [W-1:0] r;
      bit           ok;
      int           d0;
      do_reset('0);
      run_txn(2, W'(3), W'(4), d, r, ok);
      checks++; if (!ok || d !== 3'b100 || r !== W'(7)) begin errors++; $display("FAIL stray_pre: got %b/%0d want 100/7", d, r); end
      @(negedge clk);
      d0        = done_cnt;
      stray_val = rnd_w();
      stray_fin = 1'b1;
      @(negedge clk);
      stray_fin = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (done_cnt !== d0) begin errors++; $display("FAIL stray_done: got %0d done pulses want 0", done_cnt - d0); end
      checks++; if (bus.o_result !== W'(7) || bus.o_busy !== 0)
                  begin errors++; $display("FAIL stray_result: got res=%0d busy=%b want 7/0", bus.o_result, bus.o_busy); end
   endtask

   task automatic test_reset_in_wait();
      logic [N-1:0] g, d;
      logic [W-1:0] r;
      bit           ok;
      int           d0;
      do_reset('0);
      core_lat = 5;
      run_txn(1, W'(10), W'(20), d, r, ok);
      checks++; if (!ok || r !== W'(30)) begin errors++; $display("FAIL rw_pre: got %0d want 30", r); end
      @(negedge clk);
      bus.i_req[0] = 1'b1;
      set_ops(0, W'(5), W'(6));
      wait_grant(g, ok);
      bus.i_req[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.o_busy !== 0 || bus.o_mm_start !== 0 || bus.o_grant !== '0 || bus.o_done !== '0)
                  begin errors++; $display("FAIL rw_ctrl: got busy=%b start=%b grant=%b done=%b want all 0",
                                           bus.o_busy, bus.o_mm_start, bus.o_grant, bus.o_done); end
      checks++; if (bus.o_result !== '0 || bus.o_mm_a !== '0 || bus.o_mm_b !== '0)
                  begin errors++; $display("FAIL rw_data: got res=%0d a=%0d b=%0d want 0", bus.o_result, bus.o_mm_a, bus.o_mm_b); end
      rst   = 1'b0;
      m_ptr = 0;
      d0    = done_cnt;
      repeat (12) @(negedge clk);
      checks++; if (done_cnt !== d0) begin errors++; $display("FAIL rw_no_done: got %0d done pulses want 0", done_cnt - d0); end
      run_txn(0, W'(1), W'(2), d, r, ok);
      checks++; if (!ok || d !== 3'b001 || r !== W'(3)) begin errors++; $display("FAIL rw_post: got %b/%0d want 001/3", d, r); end
   endtask

   task automatic test_timeout();
      logic [N-1:0] g, d;
      logic [W-1:0] r;
      bit           ok;
      int           n;
      do_reset('0);
      core_en = 1'b0;
      @(negedge clk);
      bus.i_req[1] = 1'b1;
      set_ops(1, rnd_w(), rnd_w());
      wait_grant(g, ok);
      bus.i_req[1] = 1'b0;
`ifdef MM_ARB_TIMEOUT_EN
      n = -1;
      for (int t = 1; t <= 40; t++) begin
         @(negedge clk);
         if (bus.o_error === 1'b1) begin n = t; break; end
      end
      checks++; if (n !== TO + 1) begin errors++; $display("FAIL to_latency: got %0d want %0d cycles after start", n, TO + 1); end
      checks++; if (bus.o_done !== 3'b010 || bus.o_result !== '0)
                  begin errors++; $display("FAIL to_done: got %b/%h want 010/0", bus.o_done, bus.o_result); end
      @(negedge clk);
      checks++; if (bus.o_error !== 0 || bus.o_busy !== 0)
                  begin errors++; $display("FAIL to_pulse: got err=%b busy=%b want 0/0", bus.o_error, bus.o_busy); end
      core_en = 1'b1;
      run_txn(2, W'(4), W'(5), d, r, ok);
      checks++; if (!ok || d !== 3'b100 || r !== W'(9)) begin errors++; $display("FAIL to_recover: got %b/%0d want 100/9", d, r); end
`else
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.o_error !== 0 || bus.o_busy !== 1 || bus.o_done !== '0) n++;
      end
      checks++; if (n != 0) begin errors++; $display("FAIL wait_forever: got %0d bad cycles want 0", n); end
      d = '0; r = '0;
      do_reset('0);
      run_txn(2, W'(4), W'(5), d, r, ok);
      checks++; if (!ok || d !== 3'b100 || r !== W'(9)) begin errors++; $display("FAIL wait_recover: got %b/%0d want 100/9", d, r); end
`endif
   endtask

   task automatic test_random(input int n_txn);
      logic [N-1:0] req_s;
      logic [W-1:0] exp_res;
      int           own, gi, age, ndone, maxw;
      bit           outst;
      int           waits [N];
      do_reset('0);
      ndone = 0; outst = 1'b0; age = 0; own = 0; exp_res = '0;
      foreach (waits[i]) waits[i] = 0;
      for (int cyc = 0; cyc < 4000 && ndone < n_txn; cyc++) begin
         @(negedge clk);
         req_s = bus.i_req;
         if (bus.o_done !== '0) begin
            checks++;
            if (!outst || bus.o_done !== onehot(own) || bus.o_result !== exp_res) begin
               errors++;
               $display("FAIL rand_done: got %b/%h want %b/%h", bus.o_done, bus.o_result, onehot(own), exp_res);
            end
            outst = 1'b0;
            m_ptr = (own + 1) % N;
            ndone++;
         end
         if (bus.o_grant !== '0) begin
            gi = rr_pick(req_s, m_ptr);
            checks++;
            if (outst || gi < 0 || bus.o_grant !== onehot(gi)) begin
               errors++;
               $display("FAIL rand_grant: got %b want index %0d (req %b ptr %0d)", bus.o_grant, gi, req_s, m_ptr);
            end
            if (gi >= 0) begin
               own     = gi;
               exp_res = get_a(gi) + get_b(gi);
               outst   = 1'b1;
               age     = 0;
               maxw    = 0;
               for (int k = 0; k < N; k++) begin
                  if (k == gi) waits[k] = 0;
                  else if (req_s[k]) waits[k]++;
                  if (waits[k] > maxw) maxw = waits[k];
               end
               checks++;
               if (maxw > N - 1) begin errors++; $display("FAIL rand_fair: got wait %0d want <= %0d", maxw, N - 1); end
               bus.i_req[gi] = 1'b0;
               set_ops(gi, rnd_w(), rnd_w());
               core_lat = $urandom_range(1, 6);
            end
         end
         if (outst) begin
            age++;
            if (age > 100) begin
               checks++; errors++;
               $display("FAIL rand_stall: got no done in %0d cycles want <= 100", age);
               break;
            end
         end
         for (int k = 0; k < N; k++) begin
            if (!bus.i_req[k] && $urandom_range(0, 3) == 0) begin
               bus.i_req[k] = 1'b1;
               set_ops(k, rnd_w(), rnd_w());
            end else if (bus.i_req[k] && $urandom_range(0, 31) == 0) begin
               bus.i_req[k] = 1'b0;
               waits[k]     = 0;
            end
         end
      end
      checks++;
      if (ndone < n_txn) begin errors++; $display("FAIL rand_count: got %0d transactions want %0d", ndone, n_txn); end
      bus.i_req = '0;
   endtask

   initial begin
      rst       = 1'b1;
      bus.i_req = '0;
      bus.i_a   = '0;
      bus.i_b   = '0;
      test_reset();
      test_single();
      test_simultaneous();
      test_fairness();
      test_stray_finish();
      test_reset_in_wait();
      test_timeout();
      test_random(40);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish within 50000 cycles");
      $fatal(1, "watchdog expired");
   end
endmodule
